vending_fsm_param: RTL and testbench

//  Parametrised single-product vending controller: accumulates coin credit, vends when credit >= PRICE,

---
 rtl/vending_fsm_param.sv | 155 +++++++++++++++
 tb/tb_vending_fsm_param.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vending_fsm_param.sv
// Single-product vending controller: accumulates coin credit, vends at PRICE and pays change
// as a stream of hopper beats. Define VEND_CANCEL_EN to add the cancel/refund port.
module vending_fsm_param #(
    parameter int unsigned PRICE    = 4,
    parameter int unsigned MAX_COIN = 4,
    parameter int unsigned COIN_W   = 3,
    parameter int unsigned CREDIT_W = 4,
    parameter int unsigned CHG_COIN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [COIN_W-1:0]   coin_val,
    output logic                coin_ready,
    output logic                coin_reject,
    output logic                vend,
    input  logic                vend_ack,
    output logic                change_valid,
    output logic [COIN_W-1:0]   change_val,
    input  logic                change_ready,
`ifdef VEND_CANCEL_EN
    input  logic                cancel,
`endif
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic [1:0] {
        StCollect = 2'd0,
        StVend    = 2'd1,
        StChange  = 2'd2
    } state_e;

    localparam logic [CREDIT_W:0]   PriceW   = (CREDIT_W+1)'(PRICE);
    localparam logic [COIN_W-1:0]   MaxCoinW = COIN_W'(MAX_COIN);
    localparam logic [CREDIT_W-1:0] ChgCoinW = CREDIT_W'(CHG_COIN);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                vend_q, vend_d;
    logic                change_valid_q, change_valid_d;
    logic [COIN_W-1:0]   change_val_q, change_val_d;
    logic                coin_reject_q, coin_reject_d;

    logic                cancel_req;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W-1:0] remaining;

    // Largest coin the hopper may pay out of the amount still owed.
    function automatic logic [COIN_W-1:0] beat_val(input logic [CREDIT_W-1:0] owed);
        if (owed < ChgCoinW) begin
            return COIN_W'(owed);
        end
        return COIN_W'(ChgCoinW);
    endfunction

`ifdef VEND_CANCEL_EN
    assign cancel_req = cancel;
`else
    assign cancel_req = 1'b0;
`endif

    assign coin_ready = (state_q == StCollect) && !cancel_req;
    assign sum        = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
    assign remaining  = credit_q - CREDIT_W'(change_val_q);

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        vend_d         = vend_q;
        change_valid_d = change_valid_q;
        change_val_d   = change_val_q;
        coin_reject_d  = 1'b0;

        unique case (state_q)
            StCollect: begin
                if (cancel_req) begin
                    if (credit_q != '0) begin
                        state_d        = StChange;
                        change_valid_d = 1'b1;
                        change_val_d   = beat_val(credit_q);
                    end
                end else if (coin_valid && coin_val != '0) begin
                    if (coin_val > MaxCoinW) begin
                        coin_reject_d = 1'b1;
                    end else if (sum >= PriceW) begin
                        credit_d = CREDIT_W'(sum - PriceW);
                        vend_d   = 1'b1;
                        state_d  = StVend;
                    end else begin
                        credit_d = CREDIT_W'(sum);
                    end
                end
            end

            StVend: begin
                if (vend_ack) begin
                    vend_d = 1'b0;
                    if (credit_q != '0) begin
                        state_d        = StChange;
                        change_valid_d = 1'b1;
                        change_val_d   = beat_val(credit_q);
                    end else begin
                        state_d = StCollect;
                    end
                end
            end

            StChange: begin
                if (change_ready) begin
                    credit_d = remaining;
                    if (remaining == '0) begin
                        change_valid_d = 1'b0;
                        change_val_d   = '0;
                        state_d        = StCollect;
                    end else begin
                        change_val_d = beat_val(remaining);
                    end
                end
            end

            default: begin
                state_d        = StCollect;
                credit_d       = '0;
                vend_d         = 1'b0;
                change_valid_d = 1'b0;
                change_val_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StCollect;
            credit_q       <= '0;
            vend_q         <= 1'b0;
            change_valid_q <= 1'b0;
            change_val_q   <= '0;
            coin_reject_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            vend_q         <= vend_d;
            change_valid_q <= change_valid_d;
            change_val_q   <= change_val_d;
            coin_reject_q  <= coin_reject_d;
        end
    end

    assign credit       = credit_q;
    assign vend         = vend_q;
    assign change_valid = change_valid_q;
    assign change_val   = change_val_q;
    assign coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_vending_fsm_param.sv
// Self-checking bench for vending_fsm_param at default parameters; covers the cancel feature
// when VEND_CANCEL_EN is defined.
module tb_vending_fsm_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_valid;
    logic [2:0] coin_val;
    logic       coin_ready;
    logic       coin_reject;
    logic       vend;
    logic       vend_ack;
    logic       change_valid;
    logic [2:0] change_val;
    logic       change_ready;
    logic       cancel;
    logic [3:0] credit;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vending_fsm_param #(
        .PRICE   (4),
        .MAX_COIN(4),
        .COIN_W  (3),
        .CREDIT_W(4),
        .CHG_COIN(1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coin_valid  (coin_valid),
        .coin_val    (coin_val),
        .coin_ready  (coin_ready),
        .coin_reject (coin_reject),
        .vend        (vend),
        .vend_ack    (vend_ack),
        .change_valid(change_valid),
        .change_val  (change_val),
        .change_ready(change_ready),
`ifdef VEND_CANCEL_EN
        .cancel      (cancel),
`endif
        .credit      (credit)
    );

    // Inputs for one cycle and the outputs expected just after that cycle's edge.
    typedef struct {
        int         id;
        logic       cv;
        logic [2:0] cval;
        logic       ack;
        logic       cr;
        logic       can;
        logic [3:0] e_credit;
        logic       e_vend;
        logic       e_cvalid;
        logic [2:0] e_cval;
        logic       e_rej;
        logic       e_rdy;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[21];

    function automatic vec_t mk(input int id, input logic cv, input logic [2:0] cval,
                                input logic ack, input logic cr, input logic can,
                                input logic [3:0] e_credit, input logic e_vend,
                                input logic e_cvalid, input logic [2:0] e_cval,
                                input logic e_rej, input logic e_rdy);
        vec_t v;
        v.id = id; v.cv = cv; v.cval = cval; v.ack = ack; v.cr = cr; v.can = can;
        v.e_credit = e_credit; v.e_vend = e_vend; v.e_cvalid = e_cvalid;
        v.e_cval = e_cval; v.e_rej = e_rej; v.e_rdy = e_rdy;
        return v;
    endfunction

    task automatic check(input vec_t e);
        logic [10:0] got, want;
        got  = {credit, vend, change_valid, change_val, coin_reject, coin_ready};
        want = {e.e_credit, e.e_vend, e.e_cvalid, e.e_cval, e.e_rej, e.e_rdy};
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL vec%0d: got credit=%0d vend=%b cvalid=%b cval=%0d rej=%b rdy=%b, want credit=%0d vend=%b cvalid=%b cval=%0d rej=%b rdy=%b",
                     e.id, credit, vend, change_valid, change_val, coin_reject, coin_ready,
                     e.e_credit, e.e_vend, e.e_cvalid, e.e_cval, e.e_rej, e.e_rdy);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        coin_valid   = v.cv;
        coin_val     = v.cval;
        vend_ack     = v.ack;
        change_ready = v.cr;
        cancel       = v.can;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check(exp_q.pop_front());
    endtask

    task automatic do_reset(input int id);
        @(negedge clk);
        rst_n        = 1'b0;
        coin_valid   = 1'b0;
        coin_val     = 3'd0;
        vend_ack     = 1'b0;
        change_ready = 1'b0;
        cancel       = 1'b0;
        exp_q.push_back(mk(id, 0, 0, 0, 0, 0, 4'd0, 0, 0, 3'd0, 0, 1));
        repeat (2) @(posedge clk);
        #1;
        check(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //              id  cv cval ack cr can  credit vend cvld cval rej rdy
        tbl[0]  = mk(1,  1, 3'd1, 0, 0, 0, 4'd1, 0, 0, 3'd0, 0, 1);
        tbl[1]  = mk(2,  1, 3'd1, 0, 0, 0, 4'd2, 0, 0, 3'd0, 0, 1);
        tbl[2]  = mk(3,  1, 3'd2, 0, 0, 0, 4'd0, 1, 0, 3'd0, 0, 0);
        tbl[3]  = mk(4,  0, 3'd0, 0, 0, 0, 4'd0, 1, 0, 3'd0, 0, 0);
        tbl[4]  = mk(5,  1, 3'd4, 0, 0, 0, 4'd0, 1, 0, 3'd0, 0, 0);
        tbl[5]  = mk(6,  0, 3'd0, 1, 0, 0, 4'd0, 0, 0, 3'd0, 0, 1);
        tbl[6]  = mk(7,  0, 3'd0, 0, 1, 0, 4'd0, 0, 0, 3'd0, 0, 1);
        tbl[7]  = mk(8,  1, 3'd3, 0, 0, 0, 4'd3, 0, 0, 3'd0, 0, 1);
        tbl[8]  = mk(9,  1, 3'd4, 0, 0, 0, 4'd3, 1, 0, 3'd0, 0, 0);
        tbl[9]  = mk(10, 0, 3'd0, 1, 0, 0, 4'd3, 0, 1, 3'd1, 0, 0);
        tbl[10] = mk(11, 0, 3'd0, 0, 1, 0, 4'd2, 0, 1, 3'd1, 0, 0);
        tbl[11] = mk(12, 1, 3'd2, 1, 0, 0, 4'd2, 0, 1, 3'd1, 0, 0);
        tbl[12] = mk(13, 0, 3'd0, 0, 1, 0, 4'd1, 0, 1, 3'd1, 0, 0);
        tbl[13] = mk(14, 0, 3'd0, 0, 1, 0, 4'd0, 0, 0, 3'd0, 0, 1);
        tbl[14] = mk(15, 1, 3'd5, 0, 0, 0, 4'd0, 0, 0, 3'd0, 1, 1);
        tbl[15] = mk(16, 0, 3'd0, 0, 0, 0, 4'd0, 0, 0, 3'd0, 0, 1);
        tbl[16] = mk(17, 1, 3'd0, 0, 0, 0, 4'd0, 0, 0, 3'd0, 0, 1);
        tbl[17] = mk(18, 1, 3'd2, 0, 0, 0, 4'd2, 0, 0, 3'd0, 0, 1);
        tbl[18] = mk(19, 1, 3'd7, 0, 0, 0, 4'd2, 0, 0, 3'd0, 1, 1);
        tbl[19] = mk(20, 0, 3'd0, 1, 1, 0, 4'd2, 0, 0, 3'd0, 0, 1);
        tbl[20] = mk(21, 0, 3'd4, 0, 0, 0, 4'd2, 0, 0, 3'd0, 0, 1);

        rst_n        = 1'b0;
        coin_valid   = 1'b0;
        coin_val     = 3'd0;
        vend_ack     = 1'b0;
        change_ready = 1'b0;
        cancel       = 1'b0;
        do_reset(100);

        for (int i = 0; i < 21; i++) begin
            apply(tbl[i]);
        end

        // Credit 2 + coin 2 reaches price; reset while vend is pending.
        apply(mk(30, 1, 3'd2, 0, 0, 0, 4'd0, 1, 0, 3'd0, 0, 0));
        do_reset(101);

        // Overpay by 3, then stall the hopper mid-change and abort with reset.
        apply(mk(40, 1, 3'd3, 0, 0, 0, 4'd3, 0, 0, 3'd0, 0, 1));
        apply(mk(41, 1, 3'd4, 0, 0, 0, 4'd3, 1, 0, 3'd0, 0, 0));
        apply(mk(42, 0, 3'd0, 1, 0, 0, 4'd3, 0, 1, 3'd1, 0, 0));
        apply(mk(43, 0, 3'd0, 0, 1, 0, 4'd2, 0, 1, 3'd1, 0, 0));
        for (int i = 0; i < 4; i++) begin
            apply(mk(44 + i, 0, 3'd0, 0, 0, 0, 4'd2, 0, 1, 3'd1, 0, 0));
        end
        apply(mk(48, 0, 3'd0, 0, 1, 0, 4'd1, 0, 1, 3'd1, 0, 0));
        do_reset(102);

`ifdef VEND_CANCEL_EN
        // Cancel with nothing owed does nothing; cancel outranks a coin and refunds credit.
        apply(mk(60, 0, 3'd0, 0, 0, 1, 4'd0, 0, 0, 3'd0, 0, 0));
        apply(mk(61, 1, 3'd1, 0, 0, 0, 4'd1, 0, 0, 3'd0, 0, 1));
        apply(mk(62, 1, 3'd1, 0, 0, 0, 4'd2, 0, 0, 3'd0, 0, 1));
        apply(mk(63, 1, 3'd2, 0, 0, 1, 4'd2, 0, 1, 3'd1, 0, 0));
        apply(mk(64, 0, 3'd0, 0, 1, 1, 4'd1, 0, 1, 3'd1, 0, 0));
        apply(mk(65, 0, 3'd0, 0, 1, 0, 4'd0, 0, 0, 3'd0, 0, 1));
        apply(mk(66, 1, 3'd3, 0, 0, 0, 4'd3, 0, 0, 3'd0, 0, 1));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
